// File: rtl/nn_layer_seq_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | nn_layer_seq_pkg : shared constants, FSM encoding and width helpers   |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
package nn_layer_seq_pkg;

  // Q6.10 fixed-point data format used on the lane datapath
  localparam int FRAC = 10;
  localparam int DW   = 16;

  localparam int ST_W = 3;
  typedef logic [ST_W-1:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t CLR   = 3'd1;
  localparam state_t MAC   = 3'd2;
  localparam state_t DRAIN = 3'd3;
  localparam state_t WRITE = 3'd4;
  localparam state_t DONE  = 3'd5;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Address/count width that never collapses to zero bits
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nn_layer_seq_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | nn_layer_seq_if : layer control, RAM read and PE/output-buffer bus    |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
interface nn_layer_seq_if
  import nn_layer_seq_pkg::*;
#(
  parameter int N_PE    = 4,
  parameter int MAX_IN  = 64,
  parameter int MAX_OUT = 64
);
  localparam int G_MAX = ceil_div(MAX_OUT, N_PE);
  localparam int NIW   = width_of(MAX_IN + 1);
  localparam int NOW   = width_of(MAX_OUT + 1);
  localparam int XAW   = width_of(MAX_IN);
  localparam int WAW   = width_of(MAX_IN * G_MAX);
  localparam int OAW   = width_of(G_MAX);

  logic            start;
  logic            abort;
  logic [NIW-1:0]  n_in;
  logic [NOW-1:0]  n_out;
  logic            busy;
  logic            done;
  logic [XAW-1:0]  x_addr;
  logic [WAW-1:0]  w_addr;
  logic            rd_en;
  logic [DW-1:0]   x_rdata;
  logic [DW-1:0]   pe_x;
  logic            pe_clr;
  logic            out_wr_en;
  logic [OAW-1:0]  out_addr;
  logic [N_PE-1:0] out_mask;

  modport master (
    input  start, abort, n_in, n_out, x_rdata,
    output busy, done, x_addr, w_addr, rd_en, pe_x, pe_clr,
           out_wr_en, out_addr, out_mask
  );

  modport slave (
    output start, abort, n_in, n_out, x_rdata,
    input  busy, done, x_addr, w_addr, rd_en, pe_x, pe_clr,
           out_wr_en, out_addr, out_mask
  );

endinterface
`default_nettype wire

// File: rtl/nn_layer_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | nn_layer_seq : fully-connected layer sequencer for an N_PE MAC array  |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module nn_layer_seq
  import nn_layer_seq_pkg::*;
#(
  parameter int N_PE    = 4,
  parameter int MAX_IN  = 64,
  parameter int MAX_OUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  nn_layer_seq_if.master bus
);

  localparam int G_MAX = ceil_div(MAX_OUT, N_PE);
  localparam int NIW   = width_of(MAX_IN + 1);
  localparam int NOW   = width_of(MAX_OUT + 1);
  localparam int XAW   = width_of(MAX_IN);
  localparam int WAW   = width_of(MAX_IN * G_MAX);
  localparam int OAW   = width_of(G_MAX);
  localparam int RW    = width_of(N_PE);

  state_t          state;
  state_t          state_nx;

  logic [NIW-1:0]  k;
  logic [OAW-1:0]  g;
  logic [OAW-1:0]  g_last;
  logic [RW-1:0]   rem;
  logic [XAW-1:0]  i;
  logic [WAW-1:0]  w_base;
  logic            vld_d1;

  logic [NIW-1:0]  n_in_c;
  logic [NOW-1:0]  n_out_c;
  logic [NOW:0]    groups_sum;
  logic [NOW:0]    groups;
  logic            go;
  logic            empty;
  logic            last_mac;
  logic            last_group;
  logic [N_PE-1:0] part_mask;

  assign n_in_c  = (bus.n_in  > NIW'(MAX_IN))  ? NIW'(MAX_IN)  : bus.n_in;
  assign n_out_c = (bus.n_out > NOW'(MAX_OUT)) ? NOW'(MAX_OUT) : bus.n_out;

  assign groups_sum = {1'b0, n_out_c} + (NOW+1)'(N_PE - 1);
  assign groups     = groups_sum / (NOW+1)'(N_PE);

  assign go         = (state == IDLE) && bus.start && !bus.abort;
  assign empty      = (n_in_c == '0) || (n_out_c == '0);
  assign last_mac   = (NIW'(i) == k - NIW'(1));
  assign last_group = (g == g_last);
  assign part_mask  = (N_PE'(1) << rem) - N_PE'(1);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = empty ? DONE : CLR;
      CLR:     state_nx = MAC;
      MAC:     if (last_mac) state_nx = DRAIN;
      DRAIN:   state_nx = WRITE;
      WRITE:   state_nx = last_group ? DONE : CLR;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.abort) begin
      state_nx = IDLE;
    end
  end

  // ---------------- FSM: outputs ----------------
  // Abort silences every strobe in the cycle it is seen, before the state leaves.
  always_comb begin
    bus.done      = 1'b0;
    bus.rd_en     = 1'b0;
    bus.x_addr    = '0;
    bus.w_addr    = '0;
    bus.pe_clr    = 1'b0;
    bus.out_wr_en = 1'b0;
    bus.out_addr  = '0;
    bus.out_mask  = '0;
    if (!bus.abort) begin
      unique case (state)
        CLR: begin
          bus.pe_clr = 1'b1;
        end
        MAC: begin
          bus.rd_en  = 1'b1;
          bus.x_addr = i;
          bus.w_addr = w_base + WAW'(i);
        end
        WRITE: begin
          bus.out_wr_en = 1'b1;
          bus.out_addr  = g;
          bus.out_mask  = (last_group && (rem != '0)) ? part_mask : '1;
        end
        DONE: begin
          bus.done = 1'b1;
        end
        default: begin
          bus.done = 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = (state != IDLE);

  // The lanes accumulate every cycle, so anything not backed by a read is forced to zero.
  assign bus.pe_x = vld_d1 ? bus.x_rdata : '0;

  // ---------------- layer counters and latched geometry ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k      <= '0;
      g_last <= '0;
      rem    <= '0;
      g      <= '0;
      i      <= '0;
      w_base <= '0;
      vld_d1 <= 1'b0;
    end else begin
      vld_d1 <= bus.rd_en;
      if (go) begin
        k      <= n_in_c;
        g_last <= OAW'(groups - (NOW+1)'(1));
        rem    <= RW'(n_out_c % NOW'(N_PE));
        g      <= '0;
        w_base <= '0;
      end
      if (state == CLR) begin
        i <= '0;
      end else if (state == MAC) begin
        i <= i + XAW'(1);
      end
      // Running base replaces g*K: one add of K per finished group
      if ((state == WRITE) && !last_group && !bus.abort) begin
        g      <= g + OAW'(1);
        w_base <= w_base + WAW'(k);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nn_layer_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_nn_layer_seq : directed bench with timeline model and lane model   |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_nn_layer_seq;

  localparam int NP  = 4;
  localparam int NIW = $clog2(65);
  localparam int NOW = $clog2(65);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ob_clr = 1'b0;

  always #5 clk = ~clk;

  nn_layer_seq_if #(.N_PE(NP), .MAX_IN(64), .MAX_OUT(64)) bus ();

  nn_layer_seq #(.N_PE(NP), .MAX_IN(64), .MAX_OUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- memories, lane model, output buffer ----------------
  logic signed [15:0] x_ram [64];
  logic [63:0]        w_ram [1024];
  logic [63:0]        w_rdata;
  logic signed [31:0] acc [NP];
  logic [15:0]        outbuf [16][NP];

  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.x_rdata <= x_ram[bus.x_addr];
      w_rdata     <= w_ram[bus.w_addr];
    end
  end

  always @(posedge clk) begin
    for (int l = 0; l < NP; l++) begin
      if (bus.pe_clr) acc[l] <= 32'sd0;
      else acc[l] <= acc[l] + $signed(bus.pe_x) * $signed(w_rdata[l*16 +: 16]);
    end
  end

  always @(posedge clk) begin
    if (ob_clr) begin
      for (int gi = 0; gi < 16; gi++)
        for (int l = 0; l < NP; l++) outbuf[gi][l] <= 16'hDEAD;
    end else if (bus.out_wr_en) begin
      for (int l = 0; l < NP; l++)
        if (bus.out_mask[l]) outbuf[bus.out_addr][l] <= 16'(acc[l] >>> 10);
    end
  end

  // ---------------- timeline model ----------------
  int  cyc = 0;
  bit  m_active = 0;
  int  m_d = 0, m_K = 0, m_nout = 0, m_G = 0;
  bit  m_prev_rd = 0;
  logic [15:0] m_prev_x = '0;

  bit  e_busy, e_done, e_rd, e_clr, e_wr;
  int  e_xaddr = 0, e_waddr = 0, e_oaddr = 0, e_mask = 0;
  logic [15:0] e_pex;
  int  gg, ph;

  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
  int last_oaddr = 0, last_mask = 0, first_w = 0, last_w = 0;
  int rd_snap = 0, wr_snap = 0, done_snap = 0, t_start = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_active  = 0;
      m_prev_rd = 0;
      m_prev_x  = '0;
    end else begin
      m_prev_rd = e_rd;
      m_prev_x  = x_ram[e_xaddr];
      if (!m_active) begin
        if (bus.start && !bus.abort) begin
          m_K      = (int'(bus.n_in)  > 64) ? 64 : int'(bus.n_in);
          m_nout   = (int'(bus.n_out) > 64) ? 64 : int'(bus.n_out);
          m_G      = (m_K == 0 || m_nout == 0) ? 0 : (m_nout + NP - 1) / NP;
          m_active = 1;
          m_d      = 1;
        end
      end else if (bus.abort || m_d == m_G * (m_K + 3) + 1) begin
        m_active = 0;
      end else begin
        m_d = m_d + 1;
      end
    end
  end

  always @(negedge clk) begin
    e_busy = 0; e_done = 0; e_rd = 0; e_clr = 0; e_wr = 0;
    e_xaddr = 0; e_waddr = 0; e_oaddr = 0; e_mask = 0;
    if (!rst && m_active) begin
      e_busy = 1;
      if (!bus.abort) begin
        if (m_d == m_G * (m_K + 3) + 1) begin
          e_done = 1;
        end else begin
          gg = (m_d - 1) / (m_K + 3);
          ph = (m_d - 1) % (m_K + 3);
          if (ph == 0) begin
            e_clr = 1;
          end else if (ph <= m_K) begin
            e_rd = 1; e_xaddr = ph - 1; e_waddr = gg * m_K + ph - 1;
          end else if (ph == m_K + 2) begin
            e_wr = 1; e_oaddr = gg;
            e_mask = (gg == m_G - 1 && m_nout % NP != 0) ? (1 << (m_nout % NP)) - 1 : 15;
          end
        end
      end
    end
    e_pex = (!rst && m_prev_rd) ? m_prev_x : 16'h0;

    chk("busy",      bus.busy,      e_busy);
    chk("done",      bus.done,      e_done);
    chk("rd_en",     bus.rd_en,     e_rd);
    chk("x_addr",    bus.x_addr,    e_xaddr);
    chk("w_addr",    bus.w_addr,    e_waddr);
    chk("pe_clr",    bus.pe_clr,    e_clr);
    chk("out_wr_en", bus.out_wr_en, e_wr);
    chk("out_addr",  bus.out_addr,  e_oaddr);
    chk("out_mask",  bus.out_mask,  e_mask);
    chk("pe_x",      bus.pe_x,      e_pex);

    if (bus.rd_en) begin
      if (rd_cnt == rd_snap) first_w = int'(bus.w_addr);
      last_w = int'(bus.w_addr);
      rd_cnt++;
    end
    if (bus.out_wr_en) begin
      wr_cnt++;
      last_oaddr = int'(bus.out_addr);
      last_mask  = int'(bus.out_mask);
    end
    if (bus.done) done_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic fill_pat(input int seed);
    for (int a = 0; a < 64; a++) x_ram[a] = 16'((a % 8) * 128 - 400 + seed * 8);
    for (int a = 0; a < 1024; a++)
      for (int l = 0; l < NP; l++)
        w_ram[a][l*16 +: 16] = 16'(((a * 3 + l * 5 + seed) % 16) * 64 - 512);
  endtask

  task automatic fill_const(input logic [15:0] xv, input logic [15:0] wv);
    for (int a = 0; a < 64; a++) x_ram[a] = xv;
    for (int a = 0; a < 1024; a++) w_ram[a] = {NP{wv}};
  endtask

  function automatic logic [15:0] ref_z(input int kk, input int n);
    longint s = 0;
    logic [63:0] wd;
    for (int j = 0; j < kk; j++) begin
      wd = w_ram[(n / NP) * kk + j];
      s += longint'(x_ram[j]) * longint'($signed(wd[(n % NP)*16 +: 16]));
    end
    return 16'(s >>> 10);
  endfunction

  task automatic check_layer(input int kk, input int nout);
    for (int n = 0; n < nout; n++) chk("z", outbuf[n / NP][n % NP], ref_z(kk, n));
    if (nout % NP != 0)
      for (int l = nout % NP; l < NP; l++) chk("z_masked", outbuf[(nout - 1) / NP][l], 16'hDEAD);
  endtask

  task automatic snap();
    t_start = cyc; rd_snap = rd_cnt; wr_snap = wr_cnt; done_snap = done_cnt;
  endtask

  task automatic start_layer(input int ni, input int no);
    @(posedge clk); #1;
    ob_clr = 1;
    @(posedge clk); #1;
    ob_clr = 0;
    bus.n_in = NIW'(ni); bus.n_out = NOW'(no); bus.start = 1'b1;
    snap();
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int off);
    off = -1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (bus.done) begin off = cyc - t_start; break; end
    end
    if (off < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout t=%0t actual=none expected=done", $time);
    end
  endtask

  // ---------------- directed sequence ----------------
  int off;

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.n_in = '0; bus.n_out = '0;
    fill_pat(0);
    @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_pe_x", bus.pe_x, 0);
    chk("reset_mask", bus.out_mask, 0);
    @(posedge clk); #1 rst = 1'b0;

    // single full group
    fill_pat(1);
    start_layer(4, 4);
    wait_done(off);
    chk("t1_done_cycle", off, 8);
    chk("t1_writes", wr_cnt - wr_snap, 1);
    chk("t1_out_addr", last_oaddr, 0);
    chk("t1_out_mask", last_mask, 4'hF);
    chk("t1_first_w", first_w, 0);
    chk("t1_last_w", last_w, 3);
    check_layer(4, 4);

    // partial last group, 1.0 * 2.0 over three inputs
    fill_const(16'sd1024, 16'sd2048);
    start_layer(3, 6);
    wait_done(off);
    chk("t2_done_cycle", off, 13);
    chk("t2_writes", wr_cnt - wr_snap, 2);
    chk("t2_last_mask", last_mask, 4'h3);
    for (int n = 0; n < 6; n++) chk("t2_z_6p0", outbuf[n / NP][n % NP], 16'sd6144);
    chk("t2_lane2_untouched", outbuf[1][2], 16'hDEAD);

    // back-to-back: start held through DONE and into IDLE
    fill_pat(2);
    start_layer(5, 8);
    wait_done(off);
    chk("t3a_done_cycle", off, 17);
    check_layer(5, 8);
    #1;
    bus.n_in = NIW'(2); bus.n_out = NOW'(3); bus.start = 1'b1; ob_clr = 1;
    fill_pat(5);
    @(posedge clk); #1;
    ob_clr = 0;
    snap();
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(off);
    chk("t3b_done_cycle", off, 6);
    check_layer(2, 3);

    // abort during group 1 MAC
    fill_pat(3);
    start_layer(4, 8);
    repeat (9) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("t4_writes", wr_cnt - wr_snap, 1);
    chk("t4_no_done", done_cnt - done_snap, 0);
    chk("t4_idle", bus.busy, 0);

    // reset pulse in DRAIN of group 0
    start_layer(3, 4);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t5_busy_now", bus.busy, 0);
    chk("t5_pe_x_now", bus.pe_x, 0);
    @(posedge clk); #1 rst = 1'b0;
    chk("t5_no_done", done_cnt - done_snap, 0);
    fill_pat(4);
    start_layer(3, 5);
    wait_done(off);
    chk("t5_done_cycle", off, 13);
    check_layer(3, 5);

    // empty layer
    start_layer(0, 4);
    wait_done(off);
    chk("t6_done_cycle", off, 1);
    chk("t6_no_reads", rd_cnt - rd_snap, 0);
    chk("t6_no_writes", wr_cnt - wr_snap, 0);

    // clamping of oversized n_in and n_out
    fill_pat(6);
    start_layer(100, 2);
    wait_done(off);
    chk("t7_done_cycle", off, 68);
    check_layer(64, 2);
    start_layer(1, 100);
    wait_done(off);
    chk("t8_done_cycle", off, 65);
    chk("t8_last_w", last_w, 15);
    check_layer(1, 64);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
